mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between the instruction fetch path (iREN) and the data path (dREN/dWEN), as driven by the control unit and the request unit.
- Registered three-state grant FSM; RAM-side signals are muxed from the granted requester.
- Per-requester wait lines stall the CPU until its transfer completes.
- Cycle-count watchdog plus sticky error flag catch a hung RAM.

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-RAM arbiter bus: instruction and data requester ports plus the single RAM port.
// master is the arbiter's view; slave is the view of the requesters and RAM around it.
`timescale 1ns/1ps
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        arb_err;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_err
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to the data or instruction path, with a watchdog and sticky error flag.
// Define ARB_RR_EN to replace fixed data-first priority with an alternating priority token.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input logic           CLK,
   input logic           nRST,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_D = 2'd1,
      GNT_I = 2'd2
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             d_req, i_req, access, ram_err, grant_live, d_first;

   function automatic logic [CNT_W-1:0] wd_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   assign d_req   = bus.dREN | bus.dWEN;
   assign i_req   = bus.iREN;
   assign access  = (bus.ramstate == RAM_ACCESS);
   assign ram_err = (bus.ramstate == RAM_ERROR);
   assign grant_live = (state_q == GNT_D) ? d_req : i_req;

`ifdef ARB_RR_EN
   // tok_q high means the instruction path holds priority for the next contended grant.
   logic tok_q, tok_d;

   assign d_first = ~tok_q;

   always_comb begin
      tok_d = tok_q;
      if ((state_q == GNT_D || state_q == GNT_I) && access)
         tok_d = ~tok_q;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) tok_q <= 1'b0;
      else       tok_q <= tok_d;
   end
`else
   assign d_first = 1'b1;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (d_req && (d_first || !i_req)) state_d = GNT_D;
            else if (i_req)                   state_d = GNT_I;
         end
         GNT_D, GNT_I: begin
            if (state_q == GNT_D) begin
               bus.ramaddr  = bus.daddr;
               bus.ramstore = bus.dstore;
               bus.ramWEN   = bus.dWEN;
               bus.ramREN   = bus.dREN & ~bus.dWEN;
               bus.dwait    = ~access;
            end else begin
               bus.ramaddr  = bus.iaddr;
               bus.ramREN   = bus.iREN;
               bus.iwait    = ~access;
            end
            // Completion wins over every fault; a dropped request is a silent abort.
            if (access) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (ram_err) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (!grant_live) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == WD_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = wd_inc(cnt_q);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.iload   = bus.ramload;
   assign bus.dload   = bus.ramload;
   assign bus.arb_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case sequences, and
// randomized traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int TO = 4;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic CLK = 1'b0;
   logic nRST;
   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   typedef logic [132:0] snap_t;

   typedef struct {
      string       name;
      bit          ir, dr, dw;
      logic [31:0] ia, da, ds;
      logic [1:0]  rs;
      logic [31:0] rl;
      snap_t       exp;
   } vec_t;

   function automatic snap_t mk(bit ren, bit wen, bit iw, bit dw, bit er,
                                logic [31:0] a, logic [31:0] s, logic [31:0] l);
      return {ren, wen, iw, dw, er, a, s, l, l};
   endfunction

   function automatic snap_t snap();
      return {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.arb_err,
              bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
   endfunction

   function automatic string fmt(snap_t s);
      return $sformatf("REN=%b WEN=%b iwait=%b dwait=%b err=%b addr=%h store=%h iload=%h dload=%h",
                       s[132], s[131], s[130], s[129], s[128],
                       s[127:96], s[95:64], s[63:32], s[31:0]);
   endfunction

   task automatic chk(string nm, snap_t act, snap_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual: %s required: %s", nm, fmt(act), fmt(exp));
      end
   endtask

   task automatic drive(bit ir, bit dr, bit dw, logic [31:0] ia, logic [31:0] da,
                        logic [31:0] ds, logic [1:0] rs, logic [31:0] rl);
      bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
      bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
      bus.ramstate = rs; bus.ramload = rl;
   endtask

   // Inputs change 1ns after the rising edge, outputs are compared on the falling edge.
   task automatic vec(string nm, bit ir, bit dr, bit dw, logic [31:0] ia, logic [31:0] da,
                      logic [31:0] ds, logic [1:0] rs, logic [31:0] rl, snap_t exp);
      drive(ir, dr, dw, ia, da, ds, rs, rl);
      @(negedge CLK);
      chk(nm, snap(), exp);
      @(posedge CLK); #1;
   endtask

   task automatic pulse_reset();
      nRST = 1'b0;
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      #2;
      nRST = 1'b1;
      @(posedge CLK); #1;
   endtask

   // Reference model: who currently owns the RAM and for how long it has waited.
   int m_own;   // 0 none, 1 data, 2 instruction
   int m_age;
   bit m_err;
   bit m_tok;   // 1: instruction path has priority on contention

   task automatic model_reset();
      m_own = 0; m_age = 0; m_err = 0; m_tok = 0;
   endtask

   function automatic snap_t model_out();
      bit acc;
      acc = (bus.ramstate == ACC);
      if (m_own == 1)
         return mk(bus.dREN & ~bus.dWEN, bus.dWEN, 1'b1, ~acc, m_err,
                   bus.daddr, bus.dstore, bus.ramload);
      if (m_own == 2)
         return mk(bus.iREN, 1'b0, ~acc, 1'b1, m_err, bus.iaddr, 32'h0, bus.ramload);
      return mk(1'b0, 1'b0, 1'b1, 1'b1, m_err, 32'h0, 32'h0, bus.ramload);
   endfunction

   task automatic model_step();
      bit dp, ip, live;
      dp = bus.dREN | bus.dWEN;
      ip = bus.iREN;
      if (m_own == 0) begin
         m_age = 0;
         if (dp && ip)  m_own = (RR && m_tok) ? 2 : 1;
         else if (dp)   m_own = 1;
         else if (ip)   m_own = 2;
      end else begin
         live = (m_own == 1) ? dp : ip;
         if (bus.ramstate == ACC) begin
            m_own = 0;
            m_tok = ~m_tok;
         end else if (bus.ramstate == ERR) begin
            m_err = 1; m_own = 0;
         end else if (!live) begin
            m_own = 0;
         end else begin
            m_age++;
            if (m_age >= TO) begin
               m_err = 1; m_own = 0;
            end
         end
         if (m_own == 0) m_age = 0;
      end
   endtask

   vec_t tbl[10];

   initial begin
      snap_t idle0;
      idle0 = mk(0, 0, 1, 1, 0, 0, 0, 0);

      tbl[0] = '{"contend_idle",   1, 0, 1, 32'h40, 32'h100, 32'hDEADBEEF, FREE, 32'h0, idle0};
      tbl[1] = '{"contend_write",  1, 0, 1, 32'h40, 32'h100, 32'hDEADBEEF, ACC, 32'h11111111,
                 mk(0, 1, 1, 0, 0, 32'h100, 32'hDEADBEEF, 32'h11111111)};
      tbl[2] = '{"contend_bubble", 1, 0, 0, 32'h40, 32'h100, 32'hDEADBEEF, FREE, 32'h0, idle0};
      tbl[3] = '{"fetch_g1",       1, 0, 0, 32'h40, 32'h100, 32'hDEADBEEF, BUSY, 32'h8C410004,
                 mk(1, 0, 1, 1, 0, 32'h40, 32'h0, 32'h8C410004)};
      tbl[4] = '{"fetch_g2",       1, 0, 0, 32'h40, 32'h100, 32'hDEADBEEF, BUSY, 32'h8C410004,
                 mk(1, 0, 1, 1, 0, 32'h40, 32'h0, 32'h8C410004)};
      tbl[5] = '{"fetch_done",     1, 0, 0, 32'h40, 32'h100, 32'hDEADBEEF, ACC, 32'h8C410004,
                 mk(1, 0, 0, 1, 0, 32'h40, 32'h0, 32'h8C410004)};
      tbl[6] = '{"idle_error_ign", 0, 0, 0, 32'h40, 32'h100, 32'hDEADBEEF, ERR, 32'h0, idle0};
      tbl[7] = '{"both_idle",      0, 1, 1, 32'h40, 32'h200, 32'h00001234, FREE, 32'h0, idle0};
      tbl[8] = '{"both_write",     0, 1, 1, 32'h40, 32'h200, 32'h00001234, ACC, 32'h0,
                 mk(0, 1, 1, 0, 0, 32'h200, 32'h1234, 32'h0)};
      tbl[9] = '{"idle_access_ign",0, 0, 0, 32'h40, 32'h200, 32'h00001234, ACC, 32'h0, idle0};

      // Reset with every request asserted.
      nRST = 1'b0;
      drive(1, 1, 1, 32'h40, 32'h100, 32'hDEADBEEF, ACC, 32'h5A5A5A5A);
      #12;
      chk("reset_outputs", snap(), mk(0, 0, 1, 1, 0, 0, 0, 32'h5A5A5A5A));
      drive(0, 0, 0, 0, 0, 0, ACC, 0);
      #1 nRST = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("post_reset_idle", snap(), idle0);
      @(posedge CLK); #1;

      foreach (tbl[k])
         vec(tbl[k].name, tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].ia, tbl[k].da,
             tbl[k].ds, tbl[k].rs, tbl[k].rl, tbl[k].exp);

      // Abort: dREN drops in the second grant cycle.
      vec("abort_idle", 0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, BUSY, 0, idle0);
      vec("abort_g1",   0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, BUSY, 0,
          mk(1, 0, 1, 1, 0, 32'h300, 32'hA5A5A5A5, 0));
      vec("abort_drop", 0, 0, 0, 0, 32'h300, 32'hA5A5A5A5, BUSY, 0,
          mk(0, 0, 1, 1, 0, 32'h300, 32'hA5A5A5A5, 0));
      vec("abort_back_idle", 0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, BUSY, 0, idle0);

      // Watchdog: RAM stays BUSY for TO grant cycles.
      for (int g = 1; g <= TO; g++)
         vec($sformatf("timeout_g%0d", g), 0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, BUSY, 0,
             mk(1, 0, 1, 1, 0, 32'h300, 32'hA5A5A5A5, 0));
      vec("timeout_fired", 0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, BUSY, 0, mk(0, 0, 1, 1, 1, 0, 0, 0));
      vec("timeout_regrant", 0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, BUSY, 0,
          mk(1, 0, 1, 1, 1, 32'h300, 32'hA5A5A5A5, 0));
      vec("timeout_done", 0, 1, 0, 0, 32'h300, 32'hA5A5A5A5, ACC, 32'h77,
          mk(1, 0, 1, 0, 1, 32'h300, 32'hA5A5A5A5, 32'h77));
      vec("err_sticky", 0, 0, 0, 0, 0, 0, FREE, 0, mk(0, 0, 1, 1, 1, 0, 0, 0));

      // Reset asserted in the middle of an instruction grant.
      vec("rst_mid_idle", 1, 0, 0, 32'h44, 0, 0, BUSY, 0, mk(0, 0, 1, 1, 1, 0, 0, 0));
      drive(1, 0, 0, 32'h44, 0, 0, BUSY, 0);
      @(negedge CLK);
      chk("rst_mid_grant", snap(), mk(1, 0, 1, 1, 1, 32'h44, 0, 0));
      #2 nRST = 1'b0;
      #1 chk("rst_mid_async", snap(), mk(0, 0, 1, 1, 0, 0, 0, 0));
      @(posedge CLK); #1;
      pulse_reset();

      // ramstate ERROR during a grant.
      vec("ramerr_idle",  1, 0, 0, 32'h48, 0, 0, FREE, 0, idle0);
      vec("ramerr_grant", 1, 0, 0, 32'h48, 0, 0, ERR, 0, mk(1, 0, 1, 1, 0, 32'h48, 0, 0));
      vec("ramerr_after", 1, 0, 0, 32'h48, 0, 0, BUSY, 0, mk(0, 0, 1, 1, 1, 0, 0, 0));
      pulse_reset();
      vec("err_cleared", 0, 0, 0, 0, 0, 0, FREE, 0, idle0);

      // Saturated contention: grant order depends on the priority mode.
      pulse_reset();
      for (int k = 0; k < 8; k++) begin
         snap_t e;
         if (k % 2 == 0)
            e = mk(0, 0, 1, 1, 0, 0, 0, 32'h99);
         else if (RR && ((k / 2) % 2 == 1))
            e = mk(1, 0, 0, 1, 0, 32'h10, 0, 32'h99);
         else
            e = mk(1, 0, 1, 0, 0, 32'h20, 32'hCAFE, 32'h99);
         vec($sformatf("saturate_c%0d", k), 1, 1, 0, 32'h10, 32'h20, 32'hCAFE, ACC, 32'h99, e);
      end

      // Randomized traffic against the reference model.
      for (int b = 0; b < 4; b++) begin
         bit ir, dr, dw;
         pulse_reset();
         model_reset();
         ir = 0; dr = 0; dw = 0;
         for (int c = 0; c < 150; c++) begin
            int r;
            logic [1:0] rs;
            if ($urandom_range(0, 3) == 0) ir = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) dr = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) dw = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            rs = (r < 50) ? BUSY : (r < 80) ? ACC : (r < 83) ? ERR : FREE;
            drive(ir, dr, dw, $urandom, $urandom, $urandom, rs, $urandom);
            @(negedge CLK);
            chk($sformatf("rand_b%0d_c%0d", b, c), snap(), model_out());
            model_step();
            @(posedge CLK); #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
